// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : unified_mem_arbiter
//  Purpose  : Two-port (fetch / load-store) arbiter in front of a single-ported
//             unified memory, with a registered memory port and fetch
//             anti-starvation.
//  Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  // Fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  // Load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  // Memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              tick_tock
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [1:0] SIZE_WORD  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              owner_q, owner_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic arb_w;
  logic data_sel_w;
  logic d_gnt_w;
  logic if_gnt_w;
  logic accept_w;

  // Grants are gated by rst so nothing is accepted while reset is held.
  assign arb_w      = rst & (state_q != S_ISSUE);
  assign data_sel_w = d_req & ~(if_req & (streak_q == STARVE_LIM));
  assign d_gnt_w    = arb_w & data_sel_w;
  assign if_gnt_w   = arb_w & if_req & ~data_sel_w;
  assign accept_w   = d_gnt_w | if_gnt_w;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    owner_d     = owner_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE,
      S_RESP:  state_d = accept_w ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase

    // The streak only counts data wins that actually made a fetch wait.
    if (arb_w) begin
      if (if_gnt_w || !if_req) begin
        streak_d = 4'd0;
      end else if (d_gnt_w && (streak_q != STARVE_LIM)) begin
        streak_d = streak_q + 4'd1;
      end
    end

    if (d_gnt_w) begin
      owner_d     = 1'b1;
      mem_en_d    = 1'b1;
      mem_we_d    = d_we;
      mem_size_d  = d_size;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
    end else if (if_gnt_w) begin
      owner_d     = 1'b0;
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b0;
      mem_size_d  = SIZE_WORD;
      mem_addr_d  = if_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      streak_q    <= 4'd0;
      owner_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_gnt    = if_gnt_w;
  assign d_gnt     = d_gnt_w;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign if_valid  = (state_q == S_RESP) & ~owner_q;
  assign d_valid   = (state_q == S_RESP) & owner_q;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign tick_tock = owner_q & (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// Bench for unified_mem_arbiter: directed scenarios plus a randomized run
// checked against a cycle-count based transaction model.
module tb_unified_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_valid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_valid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          tick_tock;

  int vecs = 0;
  int errs = 0;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .tick_tock(tick_tock)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lookup(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Memory answers the cycle after mem_en; otherwise the bus carries junk.
  always @(posedge clk) begin
    mem_rdata <= mem_en ? lookup(mem_addr) : 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0; d_addr = 0; d_wdata = 0;
    if_req = 1'b1; d_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++; if (mem_en !== 1'b0)    begin errs++; $display("FAIL rst_mem_en: got %b expected 0", mem_en); end
    vecs++; if (mem_we !== 1'b0)    begin errs++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
    vecs++; if (mem_size !== 2'b00) begin errs++; $display("FAIL rst_mem_size: got %b expected 00", mem_size); end
    vecs++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
    vecs++; if (mem_wdata !== 32'h0) begin errs++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
    vecs++; if ({if_valid, d_valid, tick_tock} !== 3'b000) begin errs++; $display("FAIL rst_valids: got %b expected 000", {if_valid, d_valid, tick_tock}); end
    vecs++; if ({if_gnt, d_gnt} !== 2'b00) begin errs++; $display("FAIL rst_gnt: got %b expected 00", {if_gnt, d_gnt}); end
    if_req = 1'b0; d_req = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    vecs++; if ({if_gnt, d_gnt} !== 2'b10) begin errs++; $display("FAIL sf_gnt: got %b expected 10", {if_gnt, d_gnt}); end
    tick(); if_req = 1'b0; if_addr = 32'hFFFF_FFF0;
    @(negedge clk);
    vecs++; if (mem_en !== 1'b1)     begin errs++; $display("FAIL sf_mem_en: got %b expected 1", mem_en); end
    vecs++; if (mem_addr !== 32'h10) begin errs++; $display("FAIL sf_mem_addr: got %h expected 10", mem_addr); end
    vecs++; if ({mem_we, mem_size} !== 3'b010) begin errs++; $display("FAIL sf_we_size: got %b expected 010", {mem_we, mem_size}); end
    vecs++; if (if_valid !== 1'b0)   begin errs++; $display("FAIL sf_early_valid: got %b expected 0", if_valid); end
    tick();
    @(negedge clk);
    vecs++; if ({if_valid, d_valid} !== 2'b10) begin errs++; $display("FAIL sf_valid: got %b expected 10", {if_valid, d_valid}); end
    vecs++; if (if_rdata !== 32'h0050_0093) begin errs++; $display("FAIL sf_rdata: got %h expected 00500093", if_rdata); end
    vecs++; if (mem_en !== 1'b0) begin errs++; $display("FAIL sf_resp_mem_en: got %b expected 0", mem_en); end
    tick();
    // idle gap: nothing further requested
    @(negedge clk);
    vecs++; if ({mem_en, mem_we, tick_tock, if_valid} !== 4'b0000) begin errs++; $display("FAIL idle_gap: got %b expected 0000", {mem_en, mem_we, tick_tock, if_valid}); end
    vecs++; if (mem_addr !== 32'h10) begin errs++; $display("FAIL idle_addr_hold: got %h expected 10", mem_addr); end
    tick();
  endtask

  task automatic test_collision();
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h400;
    @(negedge clk);
    vecs++; if ({if_gnt, d_gnt} !== 2'b01) begin errs++; $display("FAIL col_c0_gnt: got %b expected 01", {if_gnt, d_gnt}); end
    tick(); d_req = 1'b0;
    @(negedge clk);
    vecs++; if ({if_gnt, d_gnt} !== 2'b00) begin errs++; $display("FAIL col_c1_gnt: got %b expected 00", {if_gnt, d_gnt}); end
    vecs++; if ({mem_en, tick_tock} !== 2'b11) begin errs++; $display("FAIL col_c1_en_tt: got %b expected 11", {mem_en, tick_tock}); end
    vecs++; if (mem_addr !== 32'h400) begin errs++; $display("FAIL col_c1_addr: got %h expected 400", mem_addr); end
    tick();
    @(negedge clk);
    vecs++; if ({d_valid, if_valid, tick_tock} !== 3'b101) begin errs++; $display("FAIL col_c2_valid_tt: got %b expected 101", {d_valid, if_valid, tick_tock}); end
    vecs++; if (d_rdata !== lookup(32'h400)) begin errs++; $display("FAIL col_c2_rdata: got %h expected %h", d_rdata, lookup(32'h400)); end
    vecs++; if (if_gnt !== 1'b1) begin errs++; $display("FAIL col_c2_if_gnt: got %b expected 1", if_gnt); end
    tick(); if_req = 1'b0;
    @(negedge clk);
    vecs++; if (mem_addr !== 32'h20) begin errs++; $display("FAIL col_c3_addr: got %h expected 20", mem_addr); end
    vecs++; if ({mem_en, tick_tock} !== 2'b10) begin errs++; $display("FAIL col_c3_en_tt: got %b expected 10", {mem_en, tick_tock}); end
    tick();
    @(negedge clk);
    vecs++; if ({if_valid, d_valid} !== 2'b10) begin errs++; $display("FAIL col_c4_valid: got %b expected 10", {if_valid, d_valid}); end
    vecs++; if (if_rdata !== lookup(32'h20)) begin errs++; $display("FAIL col_c4_rdata: got %h expected %h", if_rdata, lookup(32'h20)); end
    tick();
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 32'h401; d_wdata = 32'hAB;
    @(negedge clk);
    vecs++; if (d_gnt !== 1'b1) begin errs++; $display("FAIL st_gnt: got %b expected 1", d_gnt); end
    tick(); d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0;
    @(negedge clk);
    vecs++; if ({mem_en, mem_we, mem_size} !== 4'b1100) begin errs++; $display("FAIL st_en_we_size: got %b expected 1100", {mem_en, mem_we, mem_size}); end
    vecs++; if (mem_addr !== 32'h401) begin errs++; $display("FAIL st_addr: got %h expected 401", mem_addr); end
    vecs++; if (mem_wdata !== 32'hAB) begin errs++; $display("FAIL st_wdata: got %h expected ab", mem_wdata); end
    tick();
    @(negedge clk);
    vecs++; if ({d_valid, if_valid} !== 2'b10) begin errs++; $display("FAIL st_done: got %b expected 10", {d_valid, if_valid}); end
    tick();
    @(negedge clk);
    vecs++; if ({mem_en, mem_we, d_valid} !== 3'b000) begin errs++; $display("FAIL st_after: got %b expected 000", {mem_en, mem_we, d_valid}); end
    tick();
  endtask

  task automatic test_starvation();
    string order = "";
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h500;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      vecs++;
      if ((if_gnt | d_gnt) !== ((k % 2) == 0)) begin
        errs++; $display("FAIL starve_spacing c%0d: got %b expected %b", k, if_gnt | d_gnt, (k % 2) == 0);
      end
      if (d_gnt === 1'b1) order = {order, "D"};
      else if (if_gnt === 1'b1) order = {order, "F"};
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    vecs++;
    if (order != "DDFDDF") begin errs++; $display("FAIL starve_order: got %s expected DDFDDF", order); end
    repeat (3) tick();
  endtask

  task automatic test_reset_midflight();
    if_req = 1'b1; if_addr = 32'h44;
    @(negedge clk);
    vecs++; if (if_gnt !== 1'b1) begin errs++; $display("FAIL rmf_gnt: got %b expected 1", if_gnt); end
    tick(); if_req = 1'b0;
    rst = 1'b0; #1;
    vecs++; if ({mem_en, tick_tock} !== 2'b00) begin errs++; $display("FAIL rmf_mem_en: got %b expected 00", {mem_en, tick_tock}); end
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vecs++; if ({if_valid, d_valid, mem_en} !== 3'b000) begin errs++; $display("FAIL rmf_ghost c%0d: got %b expected 000", k, {if_valid, d_valid, mem_en}); end
      tick();
    end
    if_req = 1'b1; if_addr = 32'h48;
    @(negedge clk);
    vecs++; if (if_gnt !== 1'b1) begin errs++; $display("FAIL rmf_regnt: got %b expected 1", if_gnt); end
    tick(); if_req = 1'b0;
    tick();
    @(negedge clk);
    vecs++; if (if_valid !== 1'b1) begin errs++; $display("FAIL rmf_revalid: got %b expected 1", if_valid); end
    vecs++; if (if_rdata !== lookup(32'h48)) begin errs++; $display("FAIL rmf_rdata: got %h expected %h", if_rdata, lookup(32'h48)); end
    repeat (2) tick();
  endtask

  // Model: accepts are separated by at least two cycles; the access accepted
  // in cycle A is on the bus in A+1 and answered in A+2.
  task automatic test_random();
    int cyc = 0;
    int last_acc = -100;
    int streak = 0;
    bit acc_d = 0, acc_we = 0;
    logic [1:0]  acc_size = 0;
    logic [31:0] acc_addr = 0, acc_wdata = 0;
    bit can, exp_d, exp_f, issue, resp;
    if_req = 0; d_req = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      issue = (cyc == last_acc + 1);
      resp  = (cyc == last_acc + 2);
      vecs++; if (mem_en !== issue) begin errs++; $display("FAIL rnd_mem_en c%0d: got %b expected %b", cyc, mem_en, issue); end
      if (issue) begin
        vecs++;
        if ({mem_we, mem_size, mem_addr} !== {acc_we, acc_size, acc_addr}) begin
          errs++; $display("FAIL rnd_issue c%0d: got %b/%b/%h expected %b/%b/%h", cyc, mem_we, mem_size, mem_addr, acc_we, acc_size, acc_addr);
        end
        if (acc_we) begin
          vecs++; if (mem_wdata !== acc_wdata) begin errs++; $display("FAIL rnd_wdata c%0d: got %h expected %h", cyc, mem_wdata, acc_wdata); end
        end
      end else begin
        vecs++; if (mem_we !== 1'b0) begin errs++; $display("FAIL rnd_mem_we c%0d: got %b expected 0", cyc, mem_we); end
      end
      vecs++;
      if ({if_valid, d_valid, tick_tock} !== {resp & !acc_d, resp & acc_d, (issue | resp) & acc_d}) begin
        errs++; $display("FAIL rnd_valid c%0d: got %b expected %b", cyc, {if_valid, d_valid, tick_tock}, {resp & !acc_d, resp & acc_d, (issue | resp) & acc_d});
      end
      if (resp && !acc_d) begin
        vecs++; if (if_rdata !== lookup(acc_addr)) begin errs++; $display("FAIL rnd_if_rdata c%0d: got %h expected %h", cyc, if_rdata, lookup(acc_addr)); end
      end
      if (resp && acc_d && !acc_we) begin
        vecs++; if (d_rdata !== lookup(acc_addr)) begin errs++; $display("FAIL rnd_d_rdata c%0d: got %h expected %h", cyc, d_rdata, lookup(acc_addr)); end
      end
      can   = (cyc != last_acc + 1);
      exp_d = can && d_req && !(if_req && streak == SM);
      exp_f = can && if_req && !exp_d;
      vecs++;
      if ({if_gnt, d_gnt} !== {exp_f, exp_d}) begin
        errs++; $display("FAIL rnd_gnt c%0d: got %b expected %b", cyc, {if_gnt, d_gnt}, {exp_f, exp_d});
      end
      if (can) begin
        if (exp_f || !if_req) streak = 0;
        else if (exp_d && streak < SM) streak++;
      end
      if (exp_d) begin
        last_acc = cyc; acc_d = 1; acc_we = d_we; acc_size = d_size; acc_addr = d_addr; acc_wdata = d_wdata;
      end else if (exp_f) begin
        last_acc = cyc; acc_d = 0; acc_we = 0; acc_size = 2'b10; acc_addr = if_addr;
      end
      tick();
      cyc++;
      if (exp_f) if_req = 1'b0;
      if (exp_d) d_req = 1'b0;
      if (!if_req && ($urandom_range(0, 2) != 0)) begin
        if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && ($urandom_range(0, 2) != 0)) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 2));
        d_addr = $urandom; d_wdata = $urandom;
      end
    end
    if_req = 0; d_req = 0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_collision();
    test_store();
    test_starvation();
    test_reset_midflight();
    test_random();
    chk("final_idle_en", {31'd0, mem_en}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

- Sequences the single-ported unified instruction/data memory of the pipelined RISC-V core.
- Arbitrates between the IF-stage fetch port and the MEM-stage load/store port.
- Grants one access at a time and issues it on the registered memory port.
- Returns the read data with a one-cycle valid pulse; the pipeline uses the same grant/valid signals as its stall source.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, memory word width
- STARVE_MAX, 4, consecutive data accepts allowed while a fetch waits (range 1..15)
- clk  in  1  clock, rising edge
- rst  in  1  reset; active-low, asynchronous
- if_req  in  1  fetch request; held with if_addr until accepted
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_valid  out  1  fetch data valid (one-cycle pulse)
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; held with its arguments until accepted
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data accepted this cycle (combinational)
- d_valid  out  1  load data valid / store done (one-cycle pulse)
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe (registered)
- mem_we  out  1  write enable (registered)
- mem_size  out  2  access size (registered)
- mem_addr  out  ADDR_W  address (registered)
- mem_wdata  out  DATA_W  write data (registered)
- mem_rdata  in  DATA_W  read data; valid the cycle after mem_en
- tick_tock  out  1  1 while the in-flight access belongs to the data port

## Operation
- FSM states:
  - IDLE: nothing in flight.
  - ISSUE: mem_en=1.
  - RESP: mem_rdata returned.
- Arbitration runs only in IDLE and RESP. ISSUE accepts nothing; both gnt=0.
- Accept rule: x_gnt = x_req & (state ∈ {IDLE, RESP}) & arbiter selects x. Acceptance occurs at the clock edge ending that cycle.
- Once accepted, the requester may change or drop its request.
- Selection:
  - Only one requesting: that one.
  - Both requesting: data wins, unless streak == STARVE_MAX; then fetch wins.
- Starvation counter `streak`:
  - Increments on a data accept while if_req=1.
  - Clears on a fetch accept, or in any arbitration cycle with if_req=0.
  - Saturates at STARVE_MAX.
- On accept:
  - Register the winner's address (plus d_we, d_size, d_wdata for data; fetch uses we=0, size=10).
  - Register the owner bit and go to ISSUE.
- Transitions:
  - ISSUE → RESP unconditionally.
  - RESP → ISSUE if an accept occurs, otherwise → IDLE.
- In RESP:
  - owner's x_valid=1, x_rdata=mem_rdata (pass-through).
  - For stores, d_valid=1 acts as the completion ack; d_rdata is don't-care.
- Non-owner valid is 0. if_rdata/d_rdata are don't-care when their valid is 0.
- mem_* outputs are driven only in ISSUE. Otherwise mem_en=0, mem_we=0; address/data hold their last values.
- No alignment checking; d_size and d_addr pass through unchanged.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, streak=0, owner=0.
  - mem_en=0, mem_we=0, mem_size=0, mem_addr=0, mem_wdata=0.
  - if_valid=0, d_valid=0, tick_tock=0.
  - if_gnt/d_gnt are forced 0 while rst=0.
- Latency: accept in cycle A → mem_en in A+1 → valid/rdata in A+2.
- Throughput: one access per 2 cycles when requests are back-to-back, since the next accept may occur in the RESP cycle A+2.
- Reset asserted mid-access drops the access. No valid is ever produced for it; the requester must re-request after reset.
- tick_tock equals owner during ISSUE/RESP and is 0 in IDLE.
- Requests arriving during ISSUE wait; they are evaluated in the following RESP cycle.

## Test plan
- Single fetch:
  - Stimulus: IDLE, if_req=1, if_addr=0x10 in cycle 0; memory returns 0x00500093.
  - Response: if_gnt=1 in cycle 0; cycle 1 mem_en=1, mem_addr=0x10, mem_we=0, mem_size=10; cycle 2 if_valid=1, if_rdata=0x00500093.
- Collision:
  - Stimulus: both requests rise in cycle 0 (load, d_addr=0x400).
  - Response: d_gnt cycle 0; d_valid cycle 2; if_gnt cycle 2; mem_addr=if_addr in cycle 3; if_valid cycle 4; tick_tock=1 in cycles 1–2.
- Store:
  - Stimulus: d_we=1, d_size=00, d_addr=0x401, d_wdata=0xAB.
  - Response: cycle 1 mem_we=1, mem_size=00, mem_addr=0x401, mem_wdata=0xAB; d_valid=1 in cycle 2.
- Starvation:
  - Stimulus: STARVE_MAX=2; if_req and d_req held high continuously, data requester re-presents after each accept.
  - Response: accept order D, D, F, D, D, F; one accept every 2 cycles.
- Reset mid-flight:
  - Stimulus: rst low during the ISSUE cycle of a fetch.
  - Response: mem_en=0 immediately; no if_valid appears afterwards; after release, a fresh request is serviced in 2 cycles.
- Idle gap:
  - Stimulus: a single fetch with no further requests.
  - Response: RESP → IDLE, mem_en=0, tick_tock=0, streak=0.
